fetch_unit: RTL and testbench
=============================

FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter: RESET_PC, 32'h0000_0000, first fetch address after reset.
REQ-002 SHALL have ports: i_clk  input  1  rising-edge clock.
REQ-003 SHALL have ports: i_rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: o_imem_req  output  1  fetch request to instruction memory.
REQ-005 SHALL have ports: o_imem_addr  output  32  fetch address, equals current PC.
REQ-006 SHALL have ports: i_imem_ready  input  1  memory accepts request this cycle.
REQ-007 SHALL have ports: i_imem_rvalid  input  1  response data valid.
REQ-008 SHALL have ports: i_imem_rdata  input  32  fetched instruction word.
REQ-009 SHALL have ports: o_valid  output  1  o_instr/o_pc/o_pcplus4 valid toward decode.
REQ-010 SHALL have ports: i_ready  input  1  decode consumes the held instruction.
REQ-011 SHALL have ports: o_instr  output  32  held instruction; o_instr[6:0] drives decoder opcode input.
REQ-012 SHALL have ports: o_pc, o_pcplus4  output  32 each  address of held instruction and address+4.
REQ-013 SHALL have ports: i_pcsrc  input  1  redirect request (taken branch / jump).
REQ-014 SHALL have ports: i_pctarget  input  32  redirect target.
REQ-015 SHALL have ports: o_fetch_err  output  1  sticky misaligned-target flag (see Configuration).

Function
REQ-016 SHALL implement FSM states S_START, S_REQ, S_WAIT, S_VALID, S_HALT.
REQ-017 S_START: all handshake outputs low; unconditional move to S_REQ next cycle.
REQ-018 S_REQ: o_imem_req = !i_pcsrc (combinational); on o_imem_req && i_imem_ready -> S_WAIT.
REQ-019 S_WAIT: on i_imem_rvalid, latch i_imem_rdata into o_instr -> S_VALID; o_valid rises the cycle after rvalid (1-cycle latency).
REQ-020 S_VALID: o_valid=1, o_instr/o_pc/o_pcplus4 held stable until i_ready; on i_ready && !i_pcsrc, PC <= PC+4 -> S_REQ.
REQ-021 At most one outstanding memory request; i_imem_rvalid outside S_WAIT SHALL be ignored.
REQ-022 Redirect in S_REQ: PC <= target, no request issued that cycle, remain S_REQ.
REQ-023 Redirect in S_WAIT: PC <= target, set drop flag; matching rvalid discarded, drop cleared -> S_REQ; o_valid stays 0.
REQ-024 Redirect in S_VALID: held instruction discarded regardless of i_ready, PC <= target, o_valid=0 next cycle -> S_REQ.
REQ-025 Redirect coincident with rvalid in S_WAIT: response discarded, PC <= target -> S_REQ.
REQ-026 PC arithmetic SHALL be 32-bit modulo; 32'hFFFF_FFFC+4 wraps to 32'h0000_0000 without error.
REQ-027 o_pcplus4 SHALL always equal o_pc+4 (modulo 2^32).

Reset
REQ-028 i_rst SHALL asynchronously force: state S_START, PC=RESET_PC, o_instr=32'h0000_0013 (NOP), o_valid=0, o_imem_req=0, drop=0, o_fetch_err=0.
REQ-029 Reset mid-request SHALL abandon the outstanding request; a late rvalid after reset is ignored (state not S_WAIT).

Configuration
REQ-030 Macro FETCH_MISALIGN_CHK_EN defined: redirect with i_pctarget[1:0]!=2'b00 SHALL set o_fetch_err (sticky), go S_HALT; S_HALT issues no requests, o_valid=0, exits only by reset.
REQ-031 Macro undefined: i_pctarget[1:0] SHALL be forced to 2'b00, o_fetch_err tied 0, S_HALT unreachable.

Verification
REQ-032 Reset release, memory ready/rvalid 1-cycle, i_ready=1 -> first o_imem_addr 0x0, then 0x4, 0x8; o_pc tracks, o_pcplus4 = o_pc+4.
REQ-033 i_ready=0 for 5 cycles in S_VALID, rdata 0x00500093 -> o_instr/o_pc stable all 5 cycles, no new request.
REQ-034 Redirect to 0x100 while in S_WAIT at 0x8 -> rdata for 0x8 dropped, next o_imem_addr 0x100, o_valid never shows 0x8.
REQ-035 RESET_PC=32'hFFFF_FFFC, sequential fetch -> second address 0x0000_0000, o_fetch_err=0.
REQ-036 FETCH_MISALIGN_CHK_EN defined, redirect to 0x102 -> o_fetch_err=1, o_imem_req=0 until i_rst; undefined -> fetch at 0x100.
REQ-037 Assert i_rst in S_WAIT, rvalid arrives after release -> ignored, first fetch at RESET_PC.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction fetch unit: one outstanding imem request, redirect with response drop, held instruction toward decode.
// Optional misaligned-redirect trap (sticky o_fetch_err, halt) enabled by defining FETCH_MISALIGN_CHK_EN.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_ready,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_instr,
    output logic [31:0] o_pc,
    output logic [31:0] o_pcplus4,
    input  logic        i_pcsrc,
    input  logic [31:0] i_pctarget,
    output logic        o_fetch_err
);
    typedef enum logic [2:0] {S_START, S_REQ, S_WAIT, S_VALID, S_HALT} state_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    state_t      state_q, state_d;
    state_t      redirect_state;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;
    logic        drop_q, drop_d;
    logic [31:0] target;
    logic        misaligned;
    logic        redirect;

    // Redirects only matter once the unit is actively fetching; START and HALT ignore them.
    assign redirect = i_pcsrc && (state_q == S_REQ || state_q == S_WAIT || state_q == S_VALID);

`ifdef FETCH_MISALIGN_CHK_EN
    logic err_q, err_d;

    assign target      = i_pctarget;
    assign misaligned  = (i_pctarget[1:0] != 2'b00);
    assign err_d       = err_q | (redirect && misaligned);
    assign o_fetch_err = err_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) err_q <= 1'b0;
        else       err_q <= err_d;
    end
`else
    assign target      = i_pctarget & 32'hFFFF_FFFC;
    assign misaligned  = 1'b0;
    assign o_fetch_err = 1'b0;
`endif

    assign redirect_state = misaligned ? S_HALT : S_REQ;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= S_START;
            pc_q    <= RESET_PC;
            instr_q <= NOP_INSTR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
            drop_q  <= drop_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        drop_d  = drop_q;
        if (redirect) begin
            pc_d = target;
            // A redirect while the request is still in flight keeps waiting for it, then throws it away.
            if (state_q == S_WAIT && !i_imem_rvalid && !misaligned) begin
                state_d = S_WAIT;
                drop_d  = 1'b1;
            end else begin
                state_d = redirect_state;
                drop_d  = 1'b0;
            end
        end else begin
            case (state_q)
                S_START: state_d = S_REQ;
                S_REQ: begin
                    if (i_imem_ready) state_d = S_WAIT;
                end
                S_WAIT: begin
                    if (i_imem_rvalid) begin
                        drop_d = 1'b0;
                        if (drop_q) begin
                            state_d = S_REQ;
                        end else begin
                            instr_d = i_imem_rdata;
                            state_d = S_VALID;
                        end
                    end
                end
                S_VALID: begin
                    if (i_ready) begin
                        pc_d    = pc_q + 32'd4;
                        state_d = S_REQ;
                    end
                end
                S_HALT: ;
                default: state_d = S_START;
            endcase
        end
    end

    always_comb begin
        o_imem_req = 1'b0;
        o_valid    = 1'b0;
        case (state_q)
            S_REQ:   o_imem_req = !i_pcsrc;
            S_VALID: o_valid    = 1'b1;
            default: ;
        endcase
    end

    assign o_imem_addr = pc_q;
    assign o_pc        = pc_q;
    assign o_pcplus4   = pc_q + 32'd4;
    assign o_instr     = instr_q;
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: transaction-level model checked every cycle on the falling edge, plus directed scenarios.
// A second instance with RESET_PC = 32'hFFFF_FFFC covers PC wrap-around.
module tb_fetch_unit;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_ready;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;
    logic        o_valid;
    logic        i_ready;
    logic [31:0] o_instr, o_pc, o_pcplus4;
    logic        i_pcsrc;
    logic [31:0] i_pctarget;
    logic        o_fetch_err;

    logic        w_req, w_rvalid, w_valid, w_err;
    logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pcplus4;

    int n_total = 0;
    int n_pass  = 0;

    always #5 i_clk = ~i_clk;

    fetch_unit dut (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(o_imem_req), .o_imem_addr(o_imem_addr),
        .i_imem_ready(i_imem_ready), .i_imem_rvalid(i_imem_rvalid), .i_imem_rdata(i_imem_rdata),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_instr(o_instr), .o_pc(o_pc), .o_pcplus4(o_pcplus4),
        .i_pcsrc(i_pcsrc), .i_pctarget(i_pctarget), .o_fetch_err(o_fetch_err)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .i_clk(i_clk), .i_rst(i_rst),
        .o_imem_req(w_req), .o_imem_addr(w_addr),
        .i_imem_ready(1'b1), .i_imem_rvalid(w_rvalid), .i_imem_rdata(w_rdata),
        .o_valid(w_valid), .i_ready(1'b1),
        .o_instr(w_instr), .o_pc(w_pc), .o_pcplus4(w_pcplus4),
        .i_pcsrc(1'b0), .i_pctarget(32'h0), .o_fetch_err(w_err)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h10) return 32'h0050_0093;
        return {a[23:0], 8'h13} ^ 32'h5A00_0000;
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        check_output(name, {31'b0, act}, {31'b0, exp});
    endtask

    // Request capture (written only by the checker) and memory state (written only by stimulus).
    logic        req_seen = 1'b0, w_seen = 1'b0;
    logic [31:0] req_addr = '0, w_seen_addr = '0;
    logic        pend = 1'b0, mem_stall = 1'b0;
    logic [31:0] pend_addr = '0;
    logic [31:0] fire_log[$];
    logic [31:0] w_log[$];
    logic        watch8 = 1'b0, saw8 = 1'b0;

    bit          m_startup, m_halt, m_hold, m_out, m_kill, m_err;
    logic [31:0] m_pc, m_hold_pc;
    bit          can_req, redir, resp, fire, was_hold, misal;
    logic [31:0] tgt;

    always @(negedge i_clk) begin
        req_seen    = o_imem_req && i_imem_ready && !i_rst;
        req_addr    = o_imem_addr;
        w_seen      = w_req && !i_rst;
        w_seen_addr = w_addr;
        if (w_seen) w_log.push_back(w_addr);
        if (i_rst) begin
            check_bit("rst_valid", o_valid, 1'b0);
            check_bit("rst_req", o_imem_req, 1'b0);
            check_output("rst_instr", o_instr, NOP_INSTR);
            check_output("rst_pc", o_pc, 32'h0);
            check_bit("rst_err", o_fetch_err, 1'b0);
            check_output("rst_wrap_pc", w_pc, 32'hFFFF_FFFC);
            m_startup = 1; m_halt = 0; m_hold = 0; m_out = 0; m_kill = 0; m_err = 0;
            m_pc = 32'h0; m_hold_pc = 32'h0;
        end else begin
            can_req = !m_startup && !m_halt && !m_hold && !m_out;
            check_output("pcplus4", o_pcplus4, o_pc + 32'd4);
            check_output("wrap_pcplus4", w_pcplus4, w_pc + 32'd4);
            check_bit("wrap_err", w_err, 1'b0);
            if (w_valid) check_output("wrap_instr", w_instr, mem_word(w_pc));
            check_bit("valid", o_valid, m_hold);
            check_bit("imem_req", o_imem_req, can_req && !i_pcsrc);
            check_bit("fetch_err", o_fetch_err, m_err);
            if (o_imem_req) check_output("imem_addr", o_imem_addr, m_pc);
            if (m_hold) begin
                check_output("held_pc", o_pc, m_hold_pc);
                check_output("held_instr", o_instr, mem_word(m_hold_pc));
            end
            if (o_imem_req && i_imem_ready) fire_log.push_back(o_imem_addr);
            if (watch8 && o_valid && o_pc == 32'h8) saw8 = 1'b1;

`ifdef FETCH_MISALIGN_CHK_EN
            tgt   = i_pctarget;
            misal = (i_pctarget[1:0] != 2'b00);
`else
            tgt   = {i_pctarget[31:2], 2'b00};
            misal = 1'b0;
`endif
            redir    = i_pcsrc && !m_startup && !m_halt;
            resp     = i_imem_rvalid && m_out;
            fire     = can_req && !i_pcsrc && i_imem_ready;
            was_hold = m_hold;
            if (m_startup) begin
                m_startup = 0;
            end else if (redir && misal) begin
                m_halt = 1; m_err = 1; m_hold = 0; m_out = 0; m_kill = 0;
            end else if (redir) begin
                m_pc = tgt;
                m_hold = 0;
                if (resp) begin m_out = 0; m_kill = 0; end
                else if (m_out) m_kill = 1;
            end else begin
                if (resp) begin
                    m_out = 0;
                    if (!m_kill) begin m_hold = 1; m_hold_pc = m_pc; end
                    m_kill = 0;
                end
                if (fire) m_out = 1;
                if (was_hold && i_ready) begin m_hold = 0; m_pc = m_pc + 32'd4; end
            end
        end
    end

    // One clock of stimulus: memory answers one cycle after accepting a request unless stalled.
    task automatic apply_stimulus();
        @(posedge i_clk);
        #1;
        i_imem_rvalid = 1'b0;
        if (req_seen) begin pend = 1'b1; pend_addr = req_addr; end
        if (pend && !mem_stall) begin
            i_imem_rvalid = 1'b1;
            i_imem_rdata  = mem_word(pend_addr);
            pend = 1'b0;
        end
        w_rvalid = w_seen;
        w_rdata  = mem_word(w_seen_addr);
    endtask

    task automatic wait_fires(input int n);
        for (int k = 0; k < 80 && fire_log.size() < n; k++) apply_stimulus();
        check_bit("fire_timeout", fire_log.size() >= n, 1'b1);
    endtask

    task automatic wait_valid_pc(input logic [31:0] pcv);
        for (int k = 0; k < 80 && !(o_valid && o_pc == pcv); k++) apply_stimulus();
        check_bit("valid_timeout", o_valid && o_pc == pcv, 1'b1);
    endtask

    task automatic wait_req(input logic any, input logic [31:0] addr);
        for (int k = 0; k < 80 && !(o_imem_req && (any || o_imem_addr == addr)); k++) apply_stimulus();
        check_bit("req_timeout", o_imem_req, 1'b1);
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        repeat (2) apply_stimulus();
        i_rst = 1'b0;
        fire_log.delete();
    endtask

    int n;

    initial begin
        i_rst = 1'b1; i_imem_ready = 1'b1; i_imem_rvalid = 1'b0; i_imem_rdata = '0;
        i_ready = 1'b1; i_pcsrc = 1'b0; i_pctarget = '0; w_rvalid = 1'b0; w_rdata = '0;
        do_reset();

        wait_fires(5);
        check_output("seq_addr0", fire_log[0], 32'h0);
        check_output("seq_addr1", fire_log[1], 32'h4);
        check_output("seq_addr2", fire_log[2], 32'h8);
        check_bit("wrap_log_len", w_log.size() >= 2, 1'b1);
        if (w_log.size() >= 2) begin
            check_output("wrap_addr0", w_log[0], 32'hFFFF_FFFC);
            check_output("wrap_addr1", w_log[1], 32'h0000_0000);
        end

        wait_valid_pc(32'h10);
        i_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            apply_stimulus();
            check_bit("stall_valid", o_valid, 1'b1);
            check_output("stall_instr", o_instr, 32'h0050_0093);
            check_output("stall_pc", o_pc, 32'h10);
            check_bit("stall_noreq", o_imem_req, 1'b0);
        end
        i_ready = 1'b1;

        do_reset();
        wait_req(1'b0, 32'h8);
        mem_stall = 1'b1; watch8 = 1'b1; saw8 = 1'b0;
        apply_stimulus();
        i_pcsrc = 1'b1; i_pctarget = 32'h100;
        apply_stimulus();
        i_pcsrc = 1'b0; mem_stall = 1'b0;
        wait_fires(4);
        check_output("redir_addr", fire_log[3], 32'h100);
        wait_valid_pc(32'h100);
        check_bit("dropped_8_never_valid", saw8, 1'b0);
        watch8 = 1'b0;

        n = fire_log.size();
        i_pcsrc = 1'b1; i_pctarget = 32'h102;
        apply_stimulus();
        i_pcsrc = 1'b0;
`ifdef FETCH_MISALIGN_CHK_EN
        repeat (10) apply_stimulus();
        check_bit("misalign_err", o_fetch_err, 1'b1);
        check_output("misalign_no_fetch", fire_log.size(), n);
`else
        wait_fires(n + 1);
        check_output("misalign_forced", fire_log[n], 32'h100);
        check_bit("misalign_no_err", o_fetch_err, 1'b0);
`endif

        do_reset();
        wait_req(1'b1, 32'h0);
        mem_stall = 1'b1;
        apply_stimulus();
        i_rst = 1'b1;
        apply_stimulus();
        i_rst = 1'b0; mem_stall = 1'b0;
        fire_log.delete();
        wait_fires(1);
        check_output("post_rst_addr", fire_log[0], 32'h0);
        wait_valid_pc(32'h0);
        check_output("post_rst_instr", o_instr, 32'h5A00_0013);
        repeat (6) apply_stimulus();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
